// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared key codes, ALU op encoding, sequencer states and the
//               one-hot phase codes of the calculator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int unsigned c_NUM_KEYS = 16;
    localparam int unsigned c_VAL_W    = 21;

    localparam logic [3:0] c_KEY_9     = 4'd9;
    localparam logic [3:0] c_KEY_PLUS  = 4'd10;
    localparam logic [3:0] c_KEY_MINUS = 4'd11;
    localparam logic [3:0] c_KEY_MUL   = 4'd12;
    localparam logic [3:0] c_KEY_DIV   = 4'd13;
    localparam logic [3:0] c_KEY_EQ    = 4'd14;
    localparam logic [3:0] c_KEY_CLR   = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_A_ENTRY = 3'd0,
        S_B_ENTRY = 3'd1,
        S_EXEC    = 3'd2,
        S_SHOW    = 3'd3,
        S_ERR     = 3'd4
    } state_e;

    localparam logic [3:0] c_PLACE_A   = 4'b0001;
    localparam logic [3:0] c_PLACE_B   = 4'b0010;
    localparam logic [3:0] c_PLACE_RES = 4'b0100;
    localparam logic [3:0] c_PLACE_ERR = 4'b1000;

    // Operator keys 10..13 map onto ops 0..3; low two bits plus 2 does it.
    function automatic op_e op_from_key(input logic [3:0] code);
        return op_e'(code[1:0] + 2'd2);
    endfunction

    // value*10 + d as shift-add; callers guarantee the result fits.
    function automatic logic [c_VAL_W-1:0] mul10_add(input logic [c_VAL_W-1:0] v,
                                                     input logic [3:0] d);
        return (v << 3) + (v << 1) + {{(c_VAL_W-4){1'b0}}, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event.sv
// ============================================================================
// Module      : key_event
// Description : Turns level-held one-hot key codes into single press events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_decode,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    logic [15:0] prev_q;
    logic        key_valid_d;
    logic        key_valid_q;
    logic [3:0]  key_code_d;
    logic [3:0]  key_code_q;
    logic [4:0]  w_ones;

    always_comb begin
        w_ones     = '0;
        key_code_d = '0;
        for (int i = 0; i < int'(c_NUM_KEYS); i++) begin
            w_ones = w_ones + {4'd0, key_decode[i]};
            if (key_decode[i]) begin
                key_code_d = 4'(i);
            end
        end
        // Requiring prev == 0 suppresses both auto-repeat and chords that
        // partially release.
        key_valid_d = (w_ones == 5'd1) && (prev_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            prev_q      <= key_decode;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module      : calc_sequencer
// Description : Calculator control FSM: operand entry, ALU handshake with
//               watchdog, and display/phase outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
    parameter int MAX_DIGITS  = 6,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_decode,
    output logic [3:0]  state_place,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [20:0] alu_a,
    output logic [20:0] alu_b,
    input  logic        alu_done,
    input  logic [20:0] alu_result,
    input  logic        alu_err,
    output logic [20:0] disp_value,
    output logic        disp_err
);

    import calc_pkg::*;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int WW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [WW-1:0] c_WD_LAST = WW'(ALU_TIMEOUT - 1);

    logic        key_valid;
    logic [3:0]  key_code;

    state_e      state_q, state_d;
    logic [20:0] acc_a_q, acc_a_d;
    logic [20:0] acc_b_q, acc_b_d;
    logic [20:0] result_q, result_d;
    op_e         op_q, op_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wd_q, wd_d;
    logic        alu_start_q, alu_start_d;

    logic        w_is_digit;
    logic        w_is_op;
    logic        w_is_eq;
    logic        w_is_clr;
    logic        w_room;

    key_event u_key_event (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_decode (key_decode),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    assign w_is_digit = key_valid && (key_code <= c_KEY_9);
    assign w_is_op    = key_valid && (key_code >= c_KEY_PLUS) && (key_code <= c_KEY_DIV);
    assign w_is_eq    = key_valid && (key_code == c_KEY_EQ);
    assign w_is_clr   = key_valid && (key_code == c_KEY_CLR);
    assign w_room     = (count_q < c_MAX_CNT);

    always_comb begin
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        result_d    = result_q;
        op_d        = op_q;
        count_d     = count_q;
        wd_d        = wd_q;
        alu_start_d = 1'b0;

        case (state_q)
            S_A_ENTRY: begin
                if (w_is_digit && w_room) begin
                    acc_a_d = mul10_add(acc_a_q, key_code);
                    count_d = count_q + CW'(1);
                end else if (w_is_op) begin
                    op_d    = op_from_key(key_code);
                    acc_b_d = '0;
                    count_d = '0;
                    state_d = S_B_ENTRY;
                end
            end
            S_B_ENTRY: begin
                if (w_is_digit && w_room) begin
                    acc_b_d = mul10_add(acc_b_q, key_code);
                    count_d = count_q + CW'(1);
                end else if (w_is_op && (count_q == '0)) begin
                    op_d = op_from_key(key_code);
                end else if (w_is_eq) begin
                    alu_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                // The done check covers the start cycle too, so a same-cycle
                // completion is accepted.
                if (alu_done) begin
                    if (alu_err) begin
                        state_d = S_ERR;
                    end else begin
                        result_d = alu_result;
                        state_d  = S_SHOW;
                    end
                end else if (wd_q == c_WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_SHOW: begin
                if (w_is_digit) begin
                    acc_a_d = {17'd0, key_code};
                    acc_b_d = '0;
                    count_d = CW'(1);
                    state_d = S_A_ENTRY;
                end else if (w_is_op) begin
                    acc_a_d = result_q;
                    acc_b_d = '0;
                    count_d = '0;
                    op_d    = op_from_key(key_code);
                    state_d = S_B_ENTRY;
                end
            end
            S_ERR: begin
            end
            default: begin
                state_d = S_A_ENTRY;
            end
        endcase

        // Clear overrides everything, including a coincident alu_done.
        if (w_is_clr) begin
            state_d     = S_A_ENTRY;
            acc_a_d     = '0;
            acc_b_d     = '0;
            result_d    = '0;
            op_d        = OP_ADD;
            count_d     = '0;
            wd_d        = '0;
            alu_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A_ENTRY;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            result_q    <= '0;
            op_q        <= OP_ADD;
            count_q     <= '0;
            wd_q        <= '0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            result_q    <= result_d;
            op_q        <= op_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            alu_start_q <= alu_start_d;
        end
    end

    always_comb begin
        disp_value  = '0;
        state_place = c_PLACE_A;
        case (state_q)
            S_A_ENTRY: begin
                disp_value  = acc_a_q;
                state_place = c_PLACE_A;
            end
            S_B_ENTRY: begin
                disp_value  = (count_q == '0) ? acc_a_q : acc_b_q;
                state_place = c_PLACE_B;
            end
            S_EXEC: begin
                disp_value  = acc_b_q;
                state_place = c_PLACE_B;
            end
            S_SHOW: begin
                disp_value  = result_q;
                state_place = c_PLACE_RES;
            end
            S_ERR: begin
                disp_value  = '0;
                state_place = c_PLACE_ERR;
            end
            default: begin
                disp_value  = '0;
                state_place = c_PLACE_A;
            end
        endcase
    end

    // Operands stay frozen throughout EXEC because no branch there edits them.
    assign alu_start = alu_start_q;
    assign alu_op    = op_q;
    assign alu_a     = acc_a_q;
    assign alu_b     = acc_b_q;
    assign disp_err  = (state_q == S_ERR);

endmodule

`default_nettype wire
